// File: rtl/multiword_adder_pkg.sv
// Shared types and constants for the multi-word adder sequencer.
package multiword_adder_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/multiword_adder_seq_add8_core.sv
// 8-bit ripple-carry adder built from 1-bit full-adder cells; also exposes the
// carry into bit 7 so the caller can form two's-complement overflow.
module add8_fa (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (ci & (x ^ y));

endmodule

module add8_core
  import multiword_adder_pkg::*;
(
  input  logic [BYTE_W-1:0] x,
  input  logic [BYTE_W-1:0] y,
  input  logic              ci,
  output logic [BYTE_W-1:0] s,
  output logic              c7,
  output logic              co
);

  logic [BYTE_W:0] carry_s;

  assign carry_s[0] = ci;

  for (genvar i = 0; i < BYTE_W; i++) begin : g_bit
    add8_fa u_fa (
      .x  (x[i]),
      .y  (y[i]),
      .ci (carry_s[i]),
      .s  (s[i]),
      .co (carry_s[i+1])
    );
  end

  assign c7 = carry_s[BYTE_W-1];
  assign co = carry_s[BYTE_W];

endmodule

// File: rtl/multiword_adder_seq_chk.sv
// Protocol checks for the sequencer: done is a single-cycle pulse inside busy,
// and the byte index stays in range.
module multiword_adder_seq_chk #(
  parameter int NBYTES = 4,
  parameter int IDXW   = $clog2(NBYTES)
) (
  input logic            clk,
  input logic            rst,
  input logic            busy,
  input logic            done,
  input logic [IDXW-1:0] idx
);

  a_done_in_busy : assert property (@(posedge clk) disable iff (rst) done |-> busy);
  a_done_pulse   : assert property (@(posedge clk) disable iff (rst) done |=> !done);
  a_idx_range    : assert property (@(posedge clk) disable iff (rst)
                                    32'(idx) <= (NBYTES - 1));

endmodule

// File: rtl/multiword_adder_seq.sv
// Multi-word adder: one shared 8-bit adder, one byte per clock, LSB first.
// Optional subtract mode under `MULTIWORD_ADDER_SUB_EN` (adds the sub port).
module multiword_adder_seq
  import multiword_adder_pkg::*;
#(
  parameter int NBYTES = 4,
  parameter int IDXW   = $clog2(NBYTES)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [BYTE_W*NBYTES-1:0] a,
  input  logic [BYTE_W*NBYTES-1:0] b,
  input  logic                     cin,
`ifdef MULTIWORD_ADDER_SUB_EN
  input  logic                     sub,
`endif
  output logic                     busy,
  output logic                     done,
  output logic [BYTE_W*NBYTES-1:0] sum,
  output logic                     cout,
  output logic                     ovf
);

  localparam int W = BYTE_W * NBYTES;

  typedef logic [NBYTES-1:0][BYTE_W-1:0] bytes_t;

  state_t            state_q, state_d;
  bytes_t            a_q, a_d;
  bytes_t            b_q, b_d;
  bytes_t            sum_q, sum_d;
  logic              carry_q, carry_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              cout_q, cout_d;
  logic              ovf_q, ovf_d;

  logic              sub_s;
  logic [W-1:0]      b_eff_s;
  logic              cin_eff_s;
  logic [BYTE_W-1:0] core_s;
  logic              core_c7;
  logic              core_co;
  logic              last_byte_s;

`ifdef MULTIWORD_ADDER_SUB_EN
  assign sub_s = sub;
`else
  assign sub_s = 1'b0;
`endif

  // Subtraction is a + ~b + ~cin, so invert B and the carry once at accept.
  assign b_eff_s   = sub_s ? ~b : b;
  assign cin_eff_s = sub_s ? ~cin : cin;

  add8_core u_core (
    .x  (a_q[idx_q]),
    .y  (b_q[idx_q]),
    .ci (carry_q),
    .s  (core_s),
    .c7 (core_c7),
    .co (core_co)
  );

  assign last_byte_s = (idx_q == IDXW'(NBYTES - 1));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = bytes_t'(a);
          b_d     = bytes_t'(b_eff_s);
          carry_d = cin_eff_s;
          sum_d   = '0;
          cout_d  = 1'b0;
          ovf_d   = 1'b0;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end else begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      RUN: begin
        sum_d[idx_q] = core_s;
        carry_d      = core_co;
        if (last_byte_s) begin
          cout_d  = core_co;
          ovf_d   = core_c7 ^ core_co;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          idx_d   = idx_q + IDXW'(1);
          state_d = RUN;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = W'(sum_q);
  assign cout = cout_q;
  assign ovf  = ovf_q;

  multiword_adder_seq_chk #(
    .NBYTES (NBYTES),
    .IDXW   (IDXW)
  ) u_chk (
    .clk  (clk),
    .rst  (rst),
    .busy (busy_q),
    .done (done_q),
    .idx  (idx_q)
  );

endmodule

// File: tb/tb_multiword_adder_seq.sv
// Randomized self-checking bench for multiword_adder_seq against an
// arithmetic reference model (plain full-width add, signed-overflow rule).
module tb_multiword_adder_seq;

  localparam int NBYTES = 4;
  localparam int W      = 8 * NBYTES;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  multiword_adder_seq #(.NBYTES(NBYTES)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef MULTIWORD_ADDER_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: full-width integer add; subtract is a + ~b + ~cin.
  task automatic ref_add(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic ci,
                         input logic si, output logic [W-1:0] s, output logic co,
                         output logic ov);
    logic [W:0]   full;
    logic [W-1:0] bb;
    logic         cc;
    bb   = si ? ~bi : bi;
    cc   = si ? ~ci : ci;
    full = {1'b0, ai} + {1'b0, bb} + {{W{1'b0}}, cc};
    s    = full[W-1:0];
    co   = full[W];
    ov   = (ai[W-1] == bb[W-1]) && (s[W-1] != ai[W-1]);
  endtask

  // One operation; poke_edge>0 re-asserts start (with a different a) at that edge after accept.
  task automatic run_op(input string tag, input logic [W-1:0] ai, input logic [W-1:0] bi,
                        input logic ci, input logic si, input int poke_edge);
    logic [W-1:0] es;
    logic         ec;
    logic         eo;
    int           lat;
    ref_add(ai, bi, ci, si, es, ec, eo);
    a = ai; b = bi; cin = ci; sub = si; start = 1'b1;
    tick();
    start = 1'b0;
    a = $urandom; b = $urandom; cin = 1'($urandom_range(0, 1));
    chk_eq({tag, "_busy"}, 64'(busy), 64'd1);
    lat = 0;
    while (!done && lat < 3 * NBYTES) begin
      if (lat + 1 == poke_edge) begin
        start = 1'b1;
        a     = ~ai;
      end else begin
        start = 1'b0;
      end
      tick();
      lat++;
    end
    start = 1'b0;
    chk_eq({tag, "_lat"},  64'(lat),  64'(NBYTES));
    chk_eq({tag, "_sum"},  64'(sum),  64'(es));
    chk_eq({tag, "_cout"}, 64'(cout), 64'(ec));
    chk_eq({tag, "_ovf"},  64'(ovf),  64'(eo));
    tick();
    chk_eq({tag, "_done1"}, 64'(done), 64'd0);
    chk_eq({tag, "_idle"},  64'(busy), 64'd0);
    tick();
    chk_eq({tag, "_hold"}, 64'({cout, ovf, sum}), 64'({ec, eo, es}));
  endtask

  logic [W-1:0] es_g;
  logic         ec_g;
  logic         eo_g;
  int           done_edges[$];
  int           edge_n;
  logic         saw_done;

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    chk_eq("rst_state", 64'({busy, done, cout, ovf, sum}), 64'd0);

    run_op("basic",  32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 0);
    run_op("ripple", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 0);
    run_op("sovf",   32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0);
    run_op("allone", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 0);
    run_op("negovf", 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 0);
    run_op("ignrun", 32'h1234_5678, 32'h0F0F_0F0F, 1'b0, 1'b0, 2);
    run_op("igndone", 32'hCAFE_0001, 32'h0000_FFFF, 1'b1, 1'b0, NBYTES + 1);
`ifdef MULTIWORD_ADDER_SUB_EN
    run_op("sub57",  32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 0);
`endif

    for (int i = 0; i < 20; i++) begin
`ifdef MULTIWORD_ADDER_SUB_EN
      run_op("rand", $urandom, $urandom, 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 0);
`else
      run_op("rand", $urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0, 0);
`endif
    end

    // start held high: back-to-back operations every NBYTES+2 cycles
    a = 32'h89AB_CDEF; b = 32'h7654_3210; cin = 1'b1; sub = 1'b0; start = 1'b1;
    ref_add(a, b, cin, 1'b0, es_g, ec_g, eo_g);
    edge_n = 0;
    while (done_edges.size() < 3 && edge_n < 10 * NBYTES) begin
      tick();
      edge_n++;
      if (done) begin
        done_edges.push_back(edge_n);
        chk_eq("b2b_sum", 64'({cout, sum}), 64'({ec_g, es_g}));
      end
    end
    start = 1'b0;
    chk_eq("b2b_cnt", 64'(done_edges.size()), 64'd3);
    if (done_edges.size() == 3) begin
      chk_eq("b2b_per1", 64'(done_edges[1] - done_edges[0]), 64'(NBYTES + 2));
      chk_eq("b2b_per2", 64'(done_edges[2] - done_edges[1]), 64'(NBYTES + 2));
    end
    repeat (2) tick();
    chk_eq("b2b_idle", 64'(busy), 64'd0);

    // reset asserted in the 3rd RUN cycle aborts without done
    a = 32'h1111_2222; b = 32'h3333_4444; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_eq("mid_rst", 64'({busy, done, cout, ovf, sum}), 64'd0);
    saw_done = 1'b0;
    for (int i = 0; i < NBYTES + 3; i++) begin
      tick();
      saw_done |= done;
    end
    chk_eq("mid_rst_nodone", 64'(saw_done), 64'd0);
    run_op("postrst", 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, limit 200000");
    $fatal(1);
  end

endmodule

// File: doc/multiword_adder_seq.md
Name: multiword_adder_seq

Overview:
- Sequencer that reuses one 8-bit ripple-carry byte adder to add operands of NBYTES bytes, one byte per clock, LSB byte first.
- A registered carry links successive bytes.
- Sits between the control logic and the shared byte adder, trading latency for area.
- Start/busy/done handshake; the result is held stable until the next accepted start.

Parameters:
- NBYTES, 4, operand width in bytes (legal range 2..16); total width W = 8*NBYTES.
- IDXW, $clog2(NBYTES), width of the byte-index counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a new addition; accepted only in IDLE.
- a  input  W  operand A; sampled on the accept cycle only.
- b  input  W  operand B; sampled on the accept cycle only.
- cin  input  1  carry-in to byte 0; sampled on the accept cycle.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse when sum, cout and ovf are valid.
- sum  output  W  result register.
- cout  output  1  carry out of bit W-1.
- ovf  output  1  two's-complement overflow: carry into bit W-1 XOR carry out of bit W-1.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state goes to IDLE; busy, done, cout, ovf = 0; sum = 0; carry register = 0; index = 0.
  - Reset mid-operation aborts the operation with no done pulse; the partial sum is cleared.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - If start=1: latch a, b into operand registers, cin into the carry register, clear sum, set index = 0, go to RUN.
  - Otherwise stay in IDLE.
- RUN: each cycle
  - the byte adder takes a_reg[8*idx+:8], b_reg[8*idx+:8] and the carry register;
  - its result is written to sum[8*idx+:8] and its carry-out to the carry register;
  - index increments.
  - On the cycle idx = NBYTES-1: capture cout and ovf (byte-adder carry into bit 7 XOR carry out of bit 7), then go to DONE.
- DONE: done=1 for exactly one cycle, then go to IDLE.
- Timing:
  - Start accepted at edge t.
  - RUN covers edges t+1 .. t+NBYTES.
  - done is high during the cycle after edge t+NBYTES.
  - Total latency from start to done is NBYTES+1 cycles.
- start while busy (RUN or DONE): ignored, no queuing. The next start is accepted in the first IDLE cycle.
- Held values:
  - sum, cout and ovf stay unchanged from done until the next accepted start.
  - a, b and cin may change freely after the accept cycle.
- Arithmetic: sum = (a + b + cin) mod 2^W; cout = bit W of the full-width sum. There are no saturation modes.
- Index wrap: the index never exceeds NBYTES-1. It is reset to 0 on accept.

Optional Feature:
- Macro: MULTIWORD_ADDER_SUB_EN.
- When defined:
  - Adds input port sub (1 bit), sampled on the accept cycle.
  - When sub=1, the B bytes are inverted before the byte adder, and the carry register is loaded with ~cin (cin=0 gives a-b; cin=1 acts as a borrow-in).
  - cout means no-borrow; ovf is the signed subtraction overflow.
- When undefined: the sub port is absent, and the block performs addition only, identical to sub=0.

Decomposition:
- Shared package multiword_adder_pkg:
  - state enum type (IDLE, RUN, DONE);
  - BYTE_W = 8 constant.
- One sub-module add8_core:
  - combinational 8-bit ripple adder built from 1-bit full-adder cells;
  - ports: x[7:0], y[7:0], ci, s[7:0], c7 (carry into bit 7), co.
- The sequencer instantiates exactly one add8_core.

Test Plan (all with NBYTES=4):
- Basic add: a=0x0000_0001, b=0x0000_0001, cin=0, start for 1 cycle -> done at 5th cycle after accept; sum=0x0000_0002, cout=0, ovf=0.
- Full carry ripple: a=0xFFFF_FFFF, b=0x0000_0000, cin=1 -> sum=0x0000_0000, cout=1, ovf=0, done exactly 1 cycle wide.
- Signed overflow: a=0x7FFF_FFFF, b=0x0000_0001, cin=0 -> sum=0x8000_0000, cout=0, ovf=1.
- Busy/start rules:
  - Pulse start again 2 cycles after accept with a different a -> ignored, original result delivered.
  - start held high continuously -> back-to-back operations every NBYTES+2 cycles.
- Reset mid-op: assert rst in the 3rd RUN cycle -> next cycle busy=0, sum=0, no done pulse; a subsequent start completes normally.
- With MULTIWORD_ADDER_SUB_EN: a=0x0000_0005, b=0x0000_0007, sub=1, cin=0 -> sum=0xFFFF_FFFE, cout=0, ovf=0.
